// File: rtl/softmax_sched.sv
// rtl/softmax_sched.sv - command sequencer in front of the 8-column softmax core
//
// Takes LUT-load, single-vector and 8x8-tile commands from a host. It gathers
// the input rows into a local buffer so the core can be fed on back-to-back
// cycles, generates the core's lut_wr/execute/fetch/mode/in timing, and
// returns the core results as dout_valid pulses.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_valid_i/ready_o host command handshake, cmd_op_i selects the command
//                       (0 LOAD_LSB, 1 LOAD_MSB, 2 RUN_VEC, 3 RUN_TILE)
//   din_valid_i/ready_o host data row handshake, din_i carries the row
//   dout_valid_o        one-cycle result pulse with dout_o, dout_last_o
//   busy_o              high whenever a command is in progress
//   lut_ok_o            sticky LUT-loaded flags (bit0 LSB, bit1 MSB)
//   core_*              drive/observe the softmax core
module softmax_sched #(
  parameter int bw           = 8,
  parameter int col          = 8,
  parameter int LUT_CYC      = 10,
  parameter int VEC_EXEC_CYC = 9,
  parameter int VEC_LAT      = 9,
  parameter int TILE_IN_OFS  = 2,
  parameter int TILE_CYC     = 14,
  parameter int FETCH_PER    = 5,
  parameter int FETCH_OFS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  input  logic [col*bw-1:0]   din_i,
  output logic                dout_valid_o,
  output logic [col*bw-1:0]   dout_o,
  output logic                dout_last_o,
  output logic                busy_o,
  output logic [1:0]          lut_ok_o,
  output logic [col*bw-1:0]   core_in_o,
  output logic [1:0]          core_lut_wr_o,
  output logic                core_execute_o,
  output logic                core_fetch_o,
  output logic                core_mode_o,
  input  logic [col*bw-1:0]   core_out_i
);

  localparam int W = col * bw;

  // The vector phase must cover both the execute window and the result cycle.
  localparam int VEC_LAST = (VEC_LAT > VEC_EXEC_CYC - 1) ? VEC_LAT : VEC_EXEC_CYC - 1;

  localparam int CW  = $clog2(TILE_CYC + LUT_CYC + VEC_LAST + 2);
  localparam int WCW = $clog2(col + 1);
  localparam int RPW = $clog2(col);
  localparam int PW  = $clog2(FETCH_PER);

  localparam logic [CW-1:0]  C_LUT_LAST  = CW'(LUT_CYC - 1);
  localparam logic [CW-1:0]  C_VEC_EXEC  = CW'(VEC_EXEC_CYC);
  localparam logic [CW-1:0]  C_VEC_LAT   = CW'(VEC_LAT);
  localparam logic [CW-1:0]  C_VEC_LAST  = CW'(VEC_LAST);
  localparam logic [CW-1:0]  C_IN_OFS    = CW'(TILE_IN_OFS);
  localparam logic [CW-1:0]  C_IN_END    = CW'(TILE_IN_OFS + col);
  localparam logic [CW-1:0]  C_TILE_LAST = CW'(TILE_CYC - 1);
  localparam logic [PW-1:0]  P_OFS       = PW'(FETCH_OFS);
  localparam logic [PW-1:0]  P_LAST      = PW'(FETCH_PER - 1);
  localparam logic [RPW-1:0] R_LAST      = RPW'(col - 1);
  localparam logic [WCW-1:0] N_TILE      = WCW'(col);
  localparam logic [WCW-1:0] N_ONE       = WCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LUT_ISSUE,
    S_LUT_WAIT,
    S_VEC_EXEC,
    S_TILE_EXEC,
    S_FETCH
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [RPW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [1:0]       lut_ok_q, lut_ok_d;
  logic [W-1:0]     hold_q;
  logic [W-1:0]     buf_q [col];

  logic             buf_we;
  logic             drive_en;
  logic [W-1:0]     drive_row;
  logic [WCW-1:0]   need;

  assign need = (op_q == 2'd3) ? N_TILE : N_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      wcnt_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      pos_q    <= '0;
      lut_ok_q <= 2'b00;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wcnt_q   <= wcnt_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      lut_ok_q <= lut_ok_d;
      hold_q   <= core_in_o;
    end
  end

  // Row storage needs no reset: nothing is read before wcnt says it was written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wcnt_q[RPW-1:0]] <= din_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wcnt_d         = wcnt_q;
    rptr_d         = rptr_q;
    cnt_d          = cnt_q;
    pos_d          = pos_q;
    lut_ok_d       = lut_ok_q;
    buf_we         = 1'b0;
    drive_en       = 1'b0;
    drive_row      = buf_q[0];
    cmd_ready_o    = 1'b0;
    din_ready_o    = 1'b0;
    core_lut_wr_o  = 2'b00;
    core_execute_o = 1'b0;
    core_fetch_o   = 1'b0;
    core_mode_o    = 1'b0;
    dout_valid_o   = 1'b0;
    dout_last_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        cnt_d       = '0;
        pos_d       = '0;
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          state_d = S_GATHER;
        end
      end

      S_GATHER: begin
        din_ready_o = 1'b1;
        if (din_valid_i) begin
          buf_we = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          // Leave on the same edge as the last write so din_ready drops at once.
          if (wcnt_d == need) begin
            cnt_d = '0;
            case (op_q)
              2'd2:    state_d = S_VEC_EXEC;
              2'd3:    state_d = S_TILE_EXEC;
              default: state_d = S_LUT_ISSUE;
            endcase
          end
        end
      end

      S_LUT_ISSUE: begin
        drive_en      = 1'b1;
        core_lut_wr_o = op_q[0] ? 2'b10 : 2'b01;
        cnt_d         = '0;
        state_d       = S_LUT_WAIT;
      end

      S_LUT_WAIT: begin
        if (cnt_q == C_LUT_LAST) begin
          lut_ok_d[op_q[0]] = 1'b1;
          state_d           = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_VEC_EXEC: begin
        drive_en       = 1'b1;
        core_execute_o = (cnt_q < C_VEC_EXEC);
        if (cnt_q == C_VEC_LAT) begin
          dout_valid_o = 1'b1;
          dout_last_o  = 1'b1;
        end
        if (cnt_q == C_VEC_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TILE_EXEC: begin
        core_mode_o    = 1'b1;
        core_execute_o = (cnt_q == '0);
        // The core samples one row per cycle in this window, so rows must
        // come from the buffer rather than straight from the host.
        if (cnt_q >= C_IN_OFS && cnt_q < C_IN_END) begin
          drive_en  = 1'b1;
          drive_row = buf_q[rptr_q];
          rptr_d    = rptr_q + 1'b1;
        end
        if (cnt_q == C_TILE_LAST) begin
          cnt_d   = '0;
          rptr_d  = '0;
          pos_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FETCH: begin
        core_mode_o  = 1'b1;
        core_fetch_o = 1'b1;
        if (pos_q == P_OFS) begin
          dout_valid_o = 1'b1;
          dout_last_o  = (rptr_q == R_LAST);
        end
        if (pos_q == P_LAST) begin
          pos_d  = '0;
          rptr_d = rptr_q + 1'b1;
          if (rptr_q == R_LAST) begin
            state_d = S_IDLE;
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      wcnt_d = '0;
      rptr_d = '0;
    end
  end

  // core_in keeps its last driven value between drive windows.
  assign core_in_o = drive_en ? drive_row : hold_q;
  assign dout_o    = dout_valid_o ? core_out_i : '0;
  assign busy_o    = ~cmd_ready_o;
  assign lut_ok_o  = lut_ok_q;

endmodule

// File: tb/tb_softmax_sched.sv
// tb/tb_softmax_sched.sv - randomized self-checking bench for softmax_sched
module tb_softmax_sched;

  logic        clk;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic        din_valid_i;
  logic        din_ready_o;
  logic [63:0] din_i;
  logic        dout_valid_o;
  logic [63:0] dout_o;
  logic        dout_last_o;
  logic        busy_o;
  logic [1:0]  lut_ok_o;
  logic [63:0] core_in_o;
  logic [1:0]  core_lut_wr_o;
  logic        core_execute_o;
  logic        core_fetch_o;
  logic        core_mode_o;
  logic [63:0] core_out_i;

  softmax_sched dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .din_valid_i    (din_valid_i),
    .din_ready_o    (din_ready_o),
    .din_i          (din_i),
    .dout_valid_o   (dout_valid_o),
    .dout_o         (dout_o),
    .dout_last_o    (dout_last_o),
    .busy_o         (busy_o),
    .lut_ok_o       (lut_ok_o),
    .core_in_o      (core_in_o),
    .core_lut_wr_o  (core_lut_wr_o),
    .core_execute_o (core_execute_o),
    .core_fetch_o   (core_fetch_o),
    .core_mode_o    (core_mode_o),
    .core_out_i     (core_out_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: output changes every cycle so a result taken on the wrong
  // cycle shows up as a data error.
  logic [63:0] salt;
  logic        cm_fixed_en;
  logic [63:0] cm_fixed;
  assign core_out_i = cm_fixed_en ? cm_fixed : (salt ^ {8{cyc[7:0]}});

  function automatic logic [63:0] model_out(input int c);
    logic [7:0] b;
    b = c[7:0];
    return cm_fixed_en ? cm_fixed : (salt ^ {8{b}});
  endfunction

  // Per-cycle trace: {ready, mode, fetch, execute, lut_wr[1:0]}
  logic [5:0]  hist     [0:16383];
  logic [63:0] cin_hist [0:16383];
  typedef struct {
    int          c;
    logic [63:0] d;
    logic        l;
  } dev_t;
  dev_t dq[$];

  always @(negedge clk) begin
    hist[cyc]     = {cmd_ready_o, core_mode_o, core_fetch_o, core_execute_o, core_lut_wr_o};
    cin_hist[cyc] = core_in_o;
    if (dout_valid_o) dq.push_back('{cyc, dout_o, dout_last_o});
  end

  int errors = 0;
  int checks = 0;
  logic [1:0] lut_model;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input int gap, input bit fixed, input logic [63:0] frow);
    logic [63:0] rows [8];
    logic [5:0]  h;
    logic [1:0]  lut_val;
    int n, t, H, R, E;
    int exec_cnt, first_exec, lut_cnt, lut_cyc, fetch_cnt, first_fetch, excl_bad, cin_bad, mode_bad;
    n = (op == 2'd3) ? 8 : 1;
    for (int k = 0; k < 8; k++) rows[k] = {$urandom, $urandom};
    if (fixed) rows[0] = frow;
    salt = {$urandom, $urandom};

    t = 0;
    while (!cmd_ready_o && t < 300) begin tick(); t++; end
    chk("idle_before_cmd", {63'd0, cmd_ready_o}, 64'd1);

    // Junk on din while idle must be ignored.
    din_valid_i = 1'b1; din_i = {$urandom, $urandom};
    tick();
    cmd_valid_i = 1'b1; cmd_op_i = op; din_i = {$urandom, $urandom};
    tick();
    cmd_valid_i = 1'b0; din_valid_i = 1'b0;
    dq.delete();

    H = 0;
    for (int k = 0; k < n; k++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) tick();
      din_valid_i = 1'b1; din_i = rows[k];
      t = 0;
      while (!din_ready_o && t < 50) begin tick(); t++; end
      H = cyc;
      tick();
      din_valid_i = 1'b0;
    end

    // Commands and data offered while busy must be ignored.
    t = 0;
    while (!cmd_ready_o && t < 200) begin
      cmd_valid_i = ($urandom_range(0, 3) == 0);
      cmd_op_i    = 2'($urandom_range(0, 3));
      din_valid_i = !din_ready_o && ($urandom_range(0, 2) == 0);
      din_i       = {$urandom, $urandom};
      tick();
      t++;
    end
    cmd_valid_i = 1'b0; din_valid_i = 1'b0;
    R = cyc;

    exec_cnt = 0; first_exec = -1; lut_cnt = 0; lut_cyc = -1; lut_val = 2'b00;
    fetch_cnt = 0; first_fetch = -1; excl_bad = 0;
    for (int c = H + 1; c < R; c++) begin
      h = hist[c];
      if (h[2]) begin exec_cnt++; if (first_exec < 0) first_exec = c; end
      if (h[3]) begin fetch_cnt++; if (first_fetch < 0) first_fetch = c; end
      if (h[1:0] != 2'b00) begin lut_cnt++; lut_cyc = c; lut_val = h[1:0]; end
      if (int'(h[1:0] != 2'b00) + int'(h[3]) + int'(h[2]) > 1) excl_bad++;
    end
    chk("one_ctrl_at_a_time", excl_bad, 0);

    if (op[1] == 1'b0) begin
      chk("lut_wr_cnt", lut_cnt, 1);
      chk("lut_wr_val", {62'd0, lut_val}, op[0] ? 64'd2 : 64'd1);
      chk("lut_wr_cyc", lut_cyc, H + 1);
      chk("lut_core_in", cin_hist[H + 1], rows[0]);
      chk("lut_ready_after_strobe", R - (H + 1), 11);
      chk("lut_no_exec_fetch", exec_cnt + fetch_cnt, 0);
      chk("lut_no_dout", dq.size(), 0);
      lut_model[op[0]] = 1'b1;
      chk("lut_ok", {62'd0, lut_ok_o}, {62'd0, lut_model});
    end else if (op == 2'd2) begin
      cin_bad = 0; mode_bad = 0;
      for (int c = H + 1; c <= H + 9; c++) begin
        if (cin_hist[c] !== rows[0]) cin_bad++;
        if (hist[c][4] !== 1'b0) mode_bad++;
      end
      chk("vec_exec_cnt", exec_cnt, 9);
      chk("vec_exec_first", first_exec, H + 1);
      chk("vec_core_in_bad", cin_bad, 0);
      chk("vec_mode_bad", mode_bad, 0);
      chk("vec_no_lut_fetch", lut_cnt + fetch_cnt, 0);
      chk("vec_dout_cnt", dq.size(), 1);
      if (dq.size() > 0) begin
        chk("vec_dout_cyc", dq[0].c, first_exec + 9);
        chk("vec_dout", dq[0].d, model_out(H + 10));
        chk("vec_dout_last", {63'd0, dq[0].l}, 64'd1);
      end
      chk("vec_ready_lat", R - H, 11);
    end else begin
      E = H + 1;
      chk("tile_exec_cnt", exec_cnt, 1);
      chk("tile_exec_cyc", first_exec, E);
      for (int k = 0; k < 8; k++) chk($sformatf("tile_row%0d", k), cin_hist[E + 2 + k], rows[k]);
      chk("tile_fetch_cnt", fetch_cnt, 40);
      chk("tile_fetch_first", first_fetch, E + 14);
      chk("tile_no_lut", lut_cnt, 0);
      mode_bad = 0;
      for (int c = E; c < E + 54; c++) if (hist[c][4] !== 1'b1) mode_bad++;
      chk("tile_mode_bad", mode_bad, 0);
      chk("tile_dout_cnt", dq.size(), 8);
      for (int k = 0; k < 8 && k < dq.size(); k++) begin
        chk($sformatf("tile_dout_cyc%0d", k), dq[k].c, E + 18 + 5 * k);
        chk($sformatf("tile_dout%0d", k), dq[k].d, model_out(E + 18 + 5 * k));
        chk($sformatf("tile_dout_last%0d", k), {63'd0, dq[k].l}, (k == 7) ? 64'd1 : 64'd0);
      end
      chk("tile_ready_lat", R - E, 54);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; din_valid_i = 1'b0; din_i = '0;
    salt = '0; cm_fixed_en = 1'b0; cm_fixed = '0; lut_model = 2'b00;
    tick();
    tick();
    chk("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_lut_ok", {62'd0, lut_ok_o}, 64'd0);
    chk("rst_core_ctrl", {59'd0, core_lut_wr_o, core_execute_o, core_fetch_o, core_mode_o}, 64'd0);
    chk("rst_core_in", core_in_o, 64'd0);
    chk("rst_dout", dout_o | {62'd0, dout_valid_o, dout_last_o}, 64'd0);
    reset = 1'b0;
    tick();

    run_cmd(2'd0, 0, 1'b1, 64'h0102030405060708);
    cm_fixed_en = 1'b1; cm_fixed = {8{8'hAA}};
    run_cmd(2'd2, 0, 1'b0, 64'd0);
    cm_fixed_en = 1'b0;
    run_cmd(2'd3, 2, 1'b0, 64'd0);

    for (int i = 0; i < 16; i++) run_cmd(2'($urandom_range(0, 3)), -1, 1'b0, 64'd0);

    // Reset in the middle of a tile pass.
    t = 0;
    while (!cmd_ready_o && t < 300) begin tick(); t++; end
    cmd_valid_i = 1'b1; cmd_op_i = 2'd3;
    tick();
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      din_valid_i = 1'b1; din_i = {$urandom, $urandom};
      t = 0;
      while (!din_ready_o && t < 50) begin tick(); t++; end
      tick();
    end
    din_valid_i = 1'b0;
    repeat (5) tick();
    chk("tile_busy_before_reset", {63'd0, busy_o}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lut_model = 2'b00;
    dq.delete();
    chk("midrst_core_ctrl", {59'd0, core_lut_wr_o, core_execute_o, core_fetch_o, core_mode_o}, 64'd0);
    chk("midrst_core_in", core_in_o, 64'd0);
    chk("midrst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
    chk("midrst_lut_ok", {62'd0, lut_ok_o}, 64'd0);
    repeat (80) tick();
    chk("midrst_no_dout", dq.size(), 0);

    run_cmd(2'd1, -1, 1'b0, 64'd0);
    run_cmd(2'd0, -1, 1'b0, 64'd0);
    run_cmd(2'd3, -1, 1'b0, 64'd0);

    t = 0;
    while (!cmd_ready_o && t < 300) begin tick(); t++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("final_rst_lut_ok", {62'd0, lut_ok_o}, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
